// File: rtl/divider_unit_pkg.sv
// Shared MDU definitions: opcodes, FSM state encoding and datapath width
// used by the sequential divider and its step logic.
package divider_unit_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [5:0] OP_MULT = 6'b011001;
  localparam logic [5:0] OP_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_unit_if.sv
// Request/response bundle between an MDU client and the divider.
// The client (master) drives the request; the divider (slave) drives the result.
interface divider_if #(
  parameter int WIDTH = 32
);

  logic               start;
  logic [5:0]         Signal;
  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  logic [2*WIDTH-1:0] dataOut;
  logic               busy;
  logic               done;
  logic               div_zero;

  modport master (
    output start, Signal, dataA, dataB,
    input  dataOut, busy, done, div_zero
  );

  modport slave (
    input  start, Signal, dataA, dataB,
    output dataOut, busy, done, div_zero
  );

endinterface

// File: rtl/divider_unit_step.sv
// One restoring-division step: shift {rem,quo} left by one, trial-subtract
// the divisor from the widened remainder and keep the result if no borrow.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] shifted_rem;
  logic             borrow;

  // The extra top bit keeps the borrow visible for remainders >= 2^(WIDTH-1).
  assign trial       = {rem_i, quo_i[WIDTH-1]} - {1'b0, divisor_i};
  assign shifted_rem = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
  assign borrow      = trial[WIDTH];

  assign rem_o = borrow ? shifted_rem : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// result {remainder, quotient} published only when the operation completes.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int         WIDTH = MDU_WIDTH,
  parameter logic [5:0] DIVU  = OP_DIVU
) (
  input  logic clk,
  input  logic reset,
  divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   div_q;
  logic               zero_pend_q;
  logic [2*WIDTH-1:0] data_out_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;

  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic               accept;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  // A divide-by-zero takes one extra cycle to publish; no new request is taken meanwhile.
  assign accept = bus.start && (bus.Signal == DIVU) && (state_q != RUN) && !zero_pend_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      zero_pend_q <= 1'b0;
      data_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else if (accept) begin
      quo_q      <= bus.dataA;
      div_q      <= bus.dataB;
      rem_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= (bus.dataB == '0);
      if (bus.dataB != '0) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        state_q     <= IDLE;
        zero_pend_q <= 1'b1;
      end
    end else if (zero_pend_q) begin
      // Quotient register still holds the dividend here.
      zero_pend_q <= 1'b0;
      data_out_q  <= {quo_q, {WIDTH{1'b1}}};
      done_q      <= 1'b1;
      busy_q      <= 1'b0;
      state_q     <= DONE;
    end else if (state_q == RUN) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        data_out_q <= {rem_d, quo_d};
        done_q     <= 1'b1;
        busy_q     <= 1'b0;
        state_q    <= DONE;
      end
    end
  end

  assign bus.dataOut  = data_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: doc/divider_unit.md
Name: divider_unit

Overview:
- Sequential unsigned restoring divider; the inverse datapath of the shift-add multiplier in the ALU/MDU.
- Accepts a 32-bit dividend and divisor on a start pulse and runs one quotient bit per cycle.
- Returns {remainder, quotient} in 64 bits. The HI/LO write-back logic loads HI from dataOut[63:32] and LO from dataOut[31:0].

Parameters:
- WIDTH, 32, operand width; dataOut is 2*WIDTH.
- DIVU, 6'b011011 (27), Signal code that enables a division.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; asserted when 0.
- start  input  1  request pulse; sampled on the rising edge.
- Signal  input  6  operation code; start is accepted only when Signal == DIVU.
- dataA  input  WIDTH  dividend.
- dataB  input  WIDTH  divisor.
- dataOut  output  2*WIDTH  {remainder, quotient}.
- busy  output  1  high while iterating.
- done  output  1  result valid; held until the next accepted start.
- div_zero  output  1  last accepted operation had divisor 0.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; dataOut=0, busy=0, done=0, div_zero=0.
  - Counter, remainder and quotient registers are cleared.
  - Reset mid-operation aborts the operation and discards it; nothing is written to dataOut.
- States: IDLE, RUN, DONE.
- Accept condition: start==1 && Signal==DIVU && state!=RUN.
  - start with any other Signal is ignored.
  - start while in RUN is ignored; the operation in flight is unaffected.
- On accept at edge T:
  - Latch dataA into the quotient shift register, dataB into the divisor register, remainder=0, counter=0.
  - Clear done; set div_zero = (dataB==0).
  - If dataB != 0: state becomes RUN and busy=1.
  - If dataB == 0: state becomes DONE at edge T+1 (skip RUN).
- Divide by zero: at edge T+1, dataOut={dataA, {WIDTH{1'b1}}}, i.e. remainder=dividend, quotient=all ones. Set done=1, busy=0.
- RUN iteration (one per edge):
  - Form {rem,quo} shifted left by 1, bringing the quo MSB into the rem LSB.
  - Compute trial = shifted_rem - divisor, WIDTH+1 bits wide.
  - If trial is non-negative: rem=trial[WIDTH-1:0] and the quo LSB = 1.
  - Otherwise: keep shifted_rem and the quo LSB = 0.
  - counter increments.
- Completion:
  - The final (WIDTH-th) iteration happens at edge T+WIDTH.
  - At that same edge: dataOut = {rem_final, quo_final}, done=1, busy=0, state=DONE.
  - Latency from accept to done is WIDTH cycles (32).
- dataOut changes only on completion or reset. It holds the previous result through IDLE and RUN and never shows partial values.
- DONE holds done=1 until the next accepted start. Back-to-back operation: a start accepted in the DONE cycle begins immediately.
- All arithmetic is unsigned. The remainder datapath is WIDTH+1 bits so the borrow is unambiguous for dividends ≥ 2^31.
- Counter width: $clog2(WIDTH)+1. It terminates exactly at WIDTH with no wrap-around.

Decomposition:
- Shared MDU package holds:
  - Opcode constants: MULT=6'b011001, DIVU=6'b011011.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH.
- One sub-module is natural: divider_step. It is combinational and covers one restoring step: inputs rem, quo, divisor; outputs next rem, next quo.
- The FSM, counter and registers stay in divider_unit.

Test Plan:
- Basic: dataA=100, dataB=7, DIVU start → busy for 32 cycles; done at T+32; dataOut=64'h00000002_0000000E; div_zero=0.
- Large dividend: dataA=32'hFFFFFFFF, dataB=1 → dataOut=64'h00000000_FFFFFFFF. Then dataA=32'hFFFFFFFF, dataB=32'h10000 → dataOut=64'h0000FFFF_0000FFFF.
- Divisor > dividend: dataA=5, dataB=10 → dataOut=64'h00000005_00000000 at T+32.
- Divide by zero: dataA=123, dataB=0 → at T+1 done=1, div_zero=1, dataOut=64'h0000007B_FFFFFFFF; busy never asserts.
- Ignored requests:
  - start with Signal=MULT (25) → no state change.
  - Second DIVU start (20/3) at T+10 of the 100/7 run → result is still 2/14 at T+32.
  - Start in the DONE cycle → 20/3 completes 32 cycles later with dataOut=64'h00000002_00000006.
- Reset mid-run: assert reset low at T+15 of 100/7 → dataOut=0, busy=0, done=0 immediately (asynchronous). After release, a new 9/4 completes with dataOut=64'h00000001_00000002.
